// File: rtl/soc_system_led_fade_driver.sv
// LED fade driver for the red-LED PIO word.
// An LED is fully on while its request bit is high. When the bit drops, the LED
// fades out through a decaying PWM duty cycle, one step per prescaler tick.
// Requests are registered on the same clk as the PIO, so no synchronisers are needed.
module soc_system_led_fade_driver #(
   parameter int N_LEDS     = 10,
   parameter int PWM_BITS   = 8,
   parameter int TICK_DIV   = 50000,
   parameter int DECAY_STEP = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [N_LEDS-1:0] led_in,
   input  logic              enable,
   output logic [N_LEDS-1:0] led_out,
   output logic [N_LEDS-1:0] active
);

   localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(TICK_DIV - 1);
   localparam logic [PWM_BITS-1:0] MAX        = '1;
   localparam logic [PWM_BITS-1:0] STEP       = PWM_BITS'(DECAY_STEP);

   logic [PRESC_W-1:0]  presc;
   logic [PRESC_W-1:0]  presc_next;
   logic                tick;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [PWM_BITS-1:0] brightness  [N_LEDS];
   logic [PWM_BITS-1:0] bright_next [N_LEDS];

   // Next prescaler value: count 0..TICK_DIV-1, then wrap to 0.
   always_comb begin
      if (presc == PRESC_LAST) presc_next = '0;
      else                     presc_next = presc + 1'b1;
   end

   // Prescaler and decay tick.
   // The tick is registered from the next prescaler value, so it is high
   // exactly on the cycle where presc == TICK_DIV-1 and is low during reset.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the values from before the edge, whatever order the blocks run in.
      if (!reset_n) begin
         presc <= '0;
         tick  <= 1'b0;
      end else begin
         presc <= presc_next;
         tick  <= (presc_next == PRESC_LAST);
      end
   end

   // Free-running PWM counter, wraps MAX -> 0. It keeps running while disabled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) pwm_cnt <= '0;
      else          pwm_cnt <= pwm_cnt + 1'b1;
   end

   // Per-channel brightness update, in priority order:
   // disable clears, request loads MAX, tick decays (saturating at 0), else hold.
   always_comb begin
      for (int i = 0; i < N_LEDS; i++) begin
         // NOTE: every path assigns bright_next[i], so no latch is inferred.
         // Any new branch added here must assign it as well.
         if (!enable)
            bright_next[i] = '0;
         else if (led_in[i])
            bright_next[i] = MAX;
         else if (tick)
            bright_next[i] = (brightness[i] < STEP) ? '0 : brightness[i] - STEP;
         else
            bright_next[i] = brightness[i];
      end
   end

   // Brightness registers.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: the brightness array is reset on purpose. An asserted reset must
      // stop every fade at once, so this state cannot come up with unknown values.
      if (!reset_n) begin
         for (int i = 0; i < N_LEDS; i++) brightness[i] <= '0;
      end else begin
         for (int i = 0; i < N_LEDS; i++) brightness[i] <= bright_next[i];
      end
   end

   // Registered PWM compare and activity flags.
   // At MAX the output stays on with no PWM gap; at 0 it stays off.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         led_out <= '0;
         active  <= '0;
      end else begin
         for (int i = 0; i < N_LEDS; i++) begin
            led_out[i] <= enable & ((brightness[i] == MAX) | (pwm_cnt < brightness[i]));
            active[i]  <= (brightness[i] != '0);
         end
      end
   end

endmodule

// File: tb/tb_soc_system_led_fade_driver.sv
// Directed testbench for soc_system_led_fade_driver.
// Uses TICK_DIV=4 and DECAY_STEP=64, so a fade runs 255 -> 191 -> 127 -> 63 -> 0.
// The bench tracks its own edge count since reset. The expected PWM counter and
// tick phase are derived from that count.
module tb_soc_system_led_fade_driver;

   logic       clk     = 1'b0;
   logic       reset_n = 1'b0;
   logic [9:0] led_in  = '0;
   logic       enable  = 1'b0;
   logic [9:0] led_out;
   logic [9:0] active;

   int edges  = 0;
   int errors = 0;
   int checks = 0;

   soc_system_led_fade_driver #(
      .N_LEDS    (10),
      .PWM_BITS  (8),
      .TICK_DIV  (4),
      .DECAY_STEP(64)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .led_in (led_in),
      .enable (enable),
      .led_out(led_out),
      .active (active)
   );

   always #5 clk = ~clk;

   // Posedges since reset release. After n edges, pwm_cnt = n%256 and presc = n%4.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) edges <= 0;
      else          edges <= edges + 1;
   end

   // Hand-computed brightness k edges after the request falls.
   // The fall is applied when edges%4 == 0, so ticks land on edges k = 4, 8, 12 and 16.
   function automatic int bexp(input int k);
      if (k < 4)       return 255;
      else if (k < 8)  return 191;
      else if (k < 12) return 127;
      else if (k < 16) return 63;
      else             return 0;
   endfunction

   // Step on negedges until edges%m == r, bounded by a cycle budget.
   task automatic wait_phase(input int m, input int r);
      for (int n = 0; n < 600 && (edges % m) != r; n++) @(negedge clk);
      checks++;
      if ((edges % m) != r) begin
         errors++;
         $display("FAIL phase_wait: edges%%%0d=%0d, required %0d", m, edges % m, r);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      enable  = 1'b1;
      led_in  = 10'h3FF;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (led_out !== 10'h000 || active !== 10'h000) begin
            errors++;
            $display("FAIL reset_hold[%0d]: led_out=%h active=%h, required 000/000", i, led_out, active);
         end
      end
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (led_out !== 10'h000 || active !== 10'h000) begin
         errors++;
         $display("FAIL reset_release: led_out=%h active=%h, required 000/000", led_out, active);
      end
      enable = 1'b0;
      led_in = 10'h000;
      repeat (2) @(negedge clk);
      checks++;
      if (led_out !== 10'h000 || active !== 10'h000) begin
         errors++;
         $display("FAIL disable_clear: led_out=%h active=%h, required 000/000", led_out, active);
      end
   endtask

   task automatic test_steady_on();
      int bad = 0;
      enable = 1'b1;
      led_in = 10'h001;
      @(negedge clk);
      checks++;
      if (led_out !== 10'h000) begin
         errors++;
         $display("FAIL load_latency: led_out=%h, required 000", led_out);
      end
      @(negedge clk);
      checks++;
      if (led_out !== 10'h001 || active !== 10'h001) begin
         errors++;
         $display("FAIL load_on: led_out=%h active=%h, required 001/001", led_out, active);
      end
      for (int i = 0; i < 512; i++) begin
         @(negedge clk);
         checks++;
         if (led_out !== 10'h001) begin
            errors++;
            bad++;
            if (bad <= 5) $display("FAIL steady_on[%0d]: led_out=%h, required 001", i, led_out);
         end
      end
   endtask

   task automatic test_fade();
      int e;
      int bprev;
      logic [9:0] exp_led;
      logic [9:0] exp_act;
      // PWM phase 180..199 over the window, so the 191 and 127 duty levels differ.
      wait_phase(256, 180);
      e = edges;
      led_in = 10'h000;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         bprev   = bexp(k - 1);
         exp_led = {9'b0, (bprev == 255) || (((e + k - 1) % 256) < bprev)};
         exp_act = {9'b0, bprev != 0};
         checks++;
         if (led_out !== exp_led || active !== exp_act) begin
            errors++;
            $display("FAIL fade[k=%0d]: led_out=%h active=%h, required %h/%h", k, led_out, active, exp_led, exp_act);
         end
      end
   endtask

   task automatic test_reassert();
      led_in = 10'h001;
      repeat (3) @(negedge clk);
      // Fall at PWM phase 100. Brightness is 127 after 11 edges, and edge 12 is a tick.
      wait_phase(256, 100);
      led_in = 10'h000;
      repeat (11) @(negedge clk);
      checks++;
      if (active !== 10'h001 || led_out !== 10'h001) begin
         errors++;
         $display("FAIL fade_mid: led_out=%h active=%h, required 001/001", led_out, active);
      end
      // Re-request on the tick cycle. If the tick won, brightness would be 63 and
      // the PWM value 112 would turn the LED off.
      led_in = 10'h001;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         checks++;
         if (led_out !== 10'h001) begin
            errors++;
            $display("FAIL reassert[%0d]: led_out=%h, required 001", j, led_out);
         end
      end
   endtask

   task automatic test_enable();
      enable = 1'b0;
      led_in = 10'h000;
      repeat (2) @(negedge clk);
      enable = 1'b1;
      led_in = 10'h2AA;
      repeat (3) @(negedge clk);
      checks++;
      if (led_out !== 10'h2AA || active !== 10'h2AA) begin
         errors++;
         $display("FAIL pattern_on: led_out=%h active=%h, required 2AA/2AA", led_out, active);
      end
      enable = 1'b0;
      @(negedge clk);
      checks++;
      if (led_out !== 10'h000) begin
         errors++;
         $display("FAIL disable_out: led_out=%h, required 000", led_out);
      end
      @(negedge clk);
      checks++;
      if (led_out !== 10'h000 || active !== 10'h000) begin
         errors++;
         $display("FAIL disable_two_edges: led_out=%h active=%h, required 000/000", led_out, active);
      end
      led_in = 10'h000;
      enable = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         checks++;
         if (led_out !== 10'h000 || active !== 10'h000) begin
            errors++;
            $display("FAIL reenable_dark[%0d]: led_out=%h active=%h, required 000/000", i, led_out, active);
         end
      end
      led_in = 10'h2AA;
      repeat (2) @(negedge clk);
      checks++;
      if (led_out !== 10'h2AA || active !== 10'h2AA) begin
         errors++;
         $display("FAIL reenable_load: led_out=%h active=%h, required 2AA/2AA", led_out, active);
      end
   endtask

   task automatic test_async_reset();
      enable = 1'b0;
      led_in = 10'h000;
      repeat (2) @(negedge clk);
      enable = 1'b1;
      led_in = 10'h007;
      repeat (3) @(negedge clk);
      led_in = 10'h000;
      repeat (5) @(negedge clk);
      checks++;
      if (active !== 10'h007) begin
         errors++;
         $display("FAIL fade_before_reset: active=%h, required 007", active);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (led_out !== 10'h000 || active !== 10'h000) begin
         errors++;
         $display("FAIL async_reset: led_out=%h active=%h, required 000/000", led_out, active);
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if (led_out !== 10'h000 || active !== 10'h000) begin
            errors++;
            $display("FAIL post_reset_dark[%0d]: led_out=%h active=%h, required 000/000", i, led_out, active);
         end
      end
   endtask

   initial begin
      test_reset();
      test_steady_on();
      test_fade();
      test_reassert();
      test_enable();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
